mc_control: RTL and testbench

Multi-cycle control unit for the single-ported RISC-V datapath. It is the parametrised successor to the combinational pipeline decoder. A state machine sequences fetch, decode, execute, memory and write-back over several cycles. It handles a ready/request memory handshake with a timeout, and adds `bne` alongside `beq`. It sits between the instruction register, the ALU zero flag and the shared instruction/data memory port.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/mem_wait_timer.sv | 24 ++
 rtl/mc_control.sv | 149 ++++++++++++++
 tb/tb_mc_control.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, state encoding and datapath select codes for the multi-cycle control unit.
package ctrl_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_RS1 = 2'b01;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // S_ prefix keeps the state names clear of the opcode constants (BRANCH).
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_TRAP
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expire fires on the last permitted wait cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // en already implies ready is low, so ready on the final cycle wins over the trap.
  assign expire = en && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RISC-V control FSM with memory ready/request handshake and wait timeout trap.
module mc_control
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [6:0] Op_i,
  input  logic [2:0] Funct3_i,
  input  logic       Zero_i,
  input  logic       MemReady_i,
  output logic       MemReq_o,
  output logic       MemWrite_o,
  output logic       IorD_o,
  output logic       IRWrite_o,
  output logic       PCWrite_o,
  output logic [1:0] PCSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic       RegWrite_o,
  output logic       MemtoReg_o,
  output logic       Busy_o,
  output logic       Trap_o
);

  state_t state, nextState;
  logic   inWait, tmrClr, tmrEn, expire;

  assign inWait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign tmrEn  = inWait && !MemReady_i;
  // Clear only on a transition into a waiting state; MEM_WR -> FETCH counts as an entry.
  assign tmrClr = (nextState != state) &&
                  ((nextState == S_FETCH) || (nextState == S_MEM_RD) || (nextState == S_MEM_WR));

  mem_wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) uTimer (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (tmrClr),
    .en     (tmrEn),
    .expire (expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE:   if (start_i) nextState = S_FETCH;
      S_FETCH: begin
        if (MemReady_i)  nextState = S_DECODE;
        else if (expire) nextState = S_TRAP;
      end
      S_DECODE: begin
        case (Op_i)
          OP:            nextState = S_EXEC_R;
          OP_IMM:        nextState = S_EXEC_I;
          LOAD, STORE:   nextState = S_ADDR;
          BRANCH:        nextState = S_BRANCH;
          default:       nextState = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: nextState = S_WB_ALU;
      S_ADDR:   nextState = (Op_i == STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (MemReady_i)  nextState = S_WB_MEM;
        else if (expire) nextState = S_TRAP;
      end
      S_MEM_WR: begin
        if (MemReady_i)  nextState = S_FETCH;
        else if (expire) nextState = S_TRAP;
      end
      S_WB_ALU, S_WB_MEM: nextState = S_FETCH;
      S_BRANCH: nextState = ((Funct3_i == F3_BEQ) || (Funct3_i == F3_BNE)) ? S_FETCH : S_TRAP;
      S_TRAP:   nextState = S_TRAP;
      default:  nextState = S_TRAP;
    endcase
  end

  // Outputs depend on the registered state; the only input terms are the
  // same-cycle write strobes (ready in FETCH, zero flag in BRANCH).
  always_comb begin
    MemReq_o   = 1'b0;
    MemWrite_o = 1'b0;
    IorD_o     = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = PCSRC_ALU;
    ALUSrcA_o  = SRCA_PC;
    ALUSrcB_o  = SRCB_RS2;
    ALUOp_o    = ALU_ADD;
    RegWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemReq_o  = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        IRWrite_o = MemReady_i;
        PCWrite_o = MemReady_i;
      end
      S_DECODE: ALUSrcB_o = SRCB_IMM;
      S_EXEC_R: begin
        ALUSrcA_o = SRCA_RS1;
        ALUOp_o   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        ALUOp_o   = ALU_FUNCT;
      end
      S_ADDR: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemReq_o = 1'b1;
        IorD_o   = 1'b1;
      end
      S_MEM_WR: begin
        MemReq_o   = 1'b1;
        IorD_o     = 1'b1;
        MemWrite_o = 1'b1;
      end
      S_WB_ALU: RegWrite_o = 1'b1;
      S_WB_MEM: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o = SRCA_RS1;
        ALUOp_o   = ALU_SUB;
        PCSrc_o   = PCSRC_ALUOUT;
        if (Funct3_i == F3_BEQ)      PCWrite_o = Zero_i;
        else if (Funct3_i == F3_BNE) PCWrite_o = !Zero_i;
      end
      default: ;
    endcase
  end

  assign Busy_o = (state != S_IDLE) && (state != S_TRAP);
  assign Trap_o = (state == S_TRAP);

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed instruction table plus random instructions vs a cycle-list model.
module tb_mc_control;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_i, start_i, Zero_i, MemReady_i;
  logic [6:0] Op_i;
  logic [2:0] Funct3_i;
  logic       MemReq_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o;
  logic [1:0] PCSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o;
  logic       RegWrite_o, MemtoReg_o, Busy_o, Trap_o;

  mc_control #(.TIMEOUT(T), .TW(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i), .Funct3_i(Funct3_i),
    .Zero_i(Zero_i), .MemReady_i(MemReady_i), .MemReq_o(MemReq_o), .MemWrite_o(MemWrite_o),
    .IorD_o(IorD_o), .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o), .PCSrc_o(PCSrc_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .Busy_o(Busy_o), .Trap_o(Trap_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rdy;
    logic [16:0] o;
  } cyc_t;
  cyc_t q[$];

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    int         fw, mw, expCyc;
    logic       expTrap, expPcw;
  } rec_t;
  rec_t tbl[15];

  function automatic logic [16:0] outv();
    return {MemReq_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o, PCSrc_o, ALUSrcA_o,
            ALUSrcB_o, ALUOp_o, RegWrite_o, MemtoReg_o, Busy_o, Trap_o};
  endfunction

  function automatic logic [16:0] ov(input int req, wr, iord, irw, pcw, pcs, sa, sb, aop,
                                     rw, m2r, busy, trp);
    return {1'(req), 1'(wr), 1'(iord), 1'(irw), 1'(pcw), 2'(pcs), 2'(sa), 2'(sb), 2'(aop),
            1'(rw), 1'(m2r), 1'(busy), 1'(trp)};
  endfunction

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reset, confirm quiet outputs, then start; returns at posedge+1 with the DUT in FETCH.
  task automatic doReset();
    rst_i = 1'b1; start_i = 1'b0; MemReady_i = 1'b0; Zero_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset", outv(), 17'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("idle", outv(), 17'd0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic pushTrap();
    q.push_back('{1'($urandom), ov(0,0,0,0,0,0,0,0,0,0,0,0,1)});
  endtask

  // Expected per-cycle outputs for one instruction, starting at its first FETCH cycle.
  task automatic buildModel(input logic [6:0] op, input logic [2:0] f3, input logic z,
                            input int fw, input int mw);
    int st, pcw;
    q.delete();
    for (int i = 0; i < fw && i < T; i++) q.push_back('{1'b0, ov(1,0,0,0,0,0,0,1,0,0,0,1,0)});
    if (fw >= T) begin pushTrap(); return; end
    q.push_back('{1'b1, ov(1,0,0,1,1,0,0,1,0,0,0,1,0)});
    q.push_back('{1'($urandom), ov(0,0,0,0,0,0,0,2,0,0,0,1,0)});
    case (op)
      7'b0110011: begin
        q.push_back('{1'($urandom), ov(0,0,0,0,0,0,1,0,2,0,0,1,0)});
        q.push_back('{1'($urandom), ov(0,0,0,0,0,0,0,0,0,1,0,1,0)});
      end
      7'b0010011: begin
        q.push_back('{1'($urandom), ov(0,0,0,0,0,0,1,2,2,0,0,1,0)});
        q.push_back('{1'($urandom), ov(0,0,0,0,0,0,0,0,0,1,0,1,0)});
      end
      7'b0000011, 7'b0100011: begin
        st = (op == 7'b0100011) ? 1 : 0;
        q.push_back('{1'($urandom), ov(0,0,0,0,0,0,1,2,0,0,0,1,0)});
        for (int i = 0; i < mw && i < T; i++) q.push_back('{1'b0, ov(1,st,1,0,0,0,0,0,0,0,0,1,0)});
        if (mw >= T) begin pushTrap(); return; end
        q.push_back('{1'b1, ov(1,st,1,0,0,0,0,0,0,0,0,1,0)});
        if (st == 0) q.push_back('{1'($urandom), ov(0,0,0,0,0,0,0,0,0,1,1,1,0)});
      end
      7'b1100011: begin
        if (f3 == 3'd0)      pcw = z ? 1 : 0;
        else if (f3 == 3'd1) pcw = z ? 0 : 1;
        else                 pcw = 0;
        q.push_back('{1'($urandom), ov(0,0,0,0,pcw,1,1,0,1,0,0,1,0)});
        if (f3 > 3'd1) pushTrap();
      end
      default: pushTrap();
    endcase
  endtask

  // Runs one directed instruction from FETCH; stimulus reacts to the request handshake.
  task automatic runDir(input rec_t r, output int cyc, output logic trp, output logic lastPcw);
    int reqCnt = 0;
    int k;
    logic prevFetch = 1'b1;
    logic isF;
    Op_i = r.op; Funct3_i = r.f3; Zero_i = r.z;
    cyc = 0; trp = 1'b0; lastPcw = 1'b0;
    for (int n = 0; n < 60; n++) begin
      isF = MemReq_o && !IorD_o;
      if (Trap_o) begin trp = 1'b1; return; end
      if (n > 0 && isF && !prevFetch) return;
      prevFetch = isF;
      if (MemReq_o) begin
        k = IorD_o ? r.mw : r.fw;
        MemReady_i = (reqCnt == k);
        if (MemReady_i) reqCnt = 0; else reqCnt++;
      end else begin
        MemReady_i = 1'($urandom);
        reqCnt = 0;
      end
      start_i = 1'($urandom);
      #1 lastPcw = PCWrite_o;
      @(posedge clk); #1;
      cyc++;
    end
    cyc = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic trp, pcw, z;
    logic [6:0] op;
    logic [2:0] f3;
    int fw, mw, sel;
    logic [6:0] badOps[3];

    rst_i = 1'b1; start_i = 1'b0; Op_i = '0; Funct3_i = '0; Zero_i = 1'b0; MemReady_i = 1'b0;

    //            op          f3    z     fw mw cyc trap  pcw
    tbl[0]  = '{7'b0110011, 3'd0, 1'b0, 0, 0, 4, 1'b0, 1'b0};
    tbl[1]  = '{7'b0010011, 3'd0, 1'b0, 2, 0, 6, 1'b0, 1'b0};
    tbl[2]  = '{7'b0000011, 3'd0, 1'b0, 0, 0, 5, 1'b0, 1'b0};
    tbl[3]  = '{7'b0000011, 3'd0, 1'b0, 0, 3, 8, 1'b0, 1'b0};
    tbl[4]  = '{7'b0100011, 3'd0, 1'b0, 1, 2, 7, 1'b0, 1'b0};
    tbl[5]  = '{7'b1100011, 3'd0, 1'b1, 0, 0, 3, 1'b0, 1'b1};
    tbl[6]  = '{7'b1100011, 3'd0, 1'b0, 0, 0, 3, 1'b0, 1'b0};
    tbl[7]  = '{7'b1100011, 3'd1, 1'b0, 0, 0, 3, 1'b0, 1'b1};
    tbl[8]  = '{7'b1100011, 3'd1, 1'b1, 0, 0, 3, 1'b0, 1'b0};
    tbl[9]  = '{7'b1100011, 3'd2, 1'b1, 0, 0, 3, 1'b1, 1'b0};
    tbl[10] = '{7'b1111111, 3'd0, 1'b0, 0, 0, 2, 1'b1, 1'b0};
    tbl[11] = '{7'b0110011, 3'd0, 1'b0, 3, 0, 7, 1'b0, 1'b0};
    tbl[12] = '{7'b0110011, 3'd0, 1'b0, 4, 0, 4, 1'b1, 1'b0};
    tbl[13] = '{7'b0000011, 3'd0, 1'b0, 0, 4, 7, 1'b1, 1'b0};
    tbl[14] = '{7'b0100011, 3'd0, 1'b0, 0, 3, 7, 1'b0, 1'b0};

    doReset();
    for (int i = 0; i < 15; i++) begin
      runDir(tbl[i], cyc, trp, pcw);
      chkInt($sformatf("row%0d_cycles", i), cyc, tbl[i].expCyc);
      chkInt($sformatf("row%0d_trap", i), int'(trp), int'(tbl[i].expTrap));
      chkInt($sformatf("row%0d_pcwrite", i), int'(pcw), int'(tbl[i].expPcw));
      if (trp) begin
        chk($sformatf("row%0d_trapOuts", i), outv(), 17'h00001);
        @(posedge clk); #1;
        chk($sformatf("row%0d_trapHold", i), outv(), 17'h00001);
        doReset();
      end
    end

    // Asynchronous reset while a load waits in MEM_RD.
    doReset();
    Op_i = 7'b0000011; Funct3_i = 3'd2; MemReady_i = 1'b1;
    @(posedge clk); #1 MemReady_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("memRdWait", outv(), ov(1,0,1,0,0,0,0,0,0,0,0,1,0));
    @(posedge clk); #2;
    rst_i = 1'b1;
    #1 chk("asyncRst", outv(), 17'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1 chk("postRstIdle", outv(), 17'd0);
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;

    // Random instruction stream against the cycle-list model.
    badOps[0] = 7'b1111111; badOps[1] = 7'b0000000; badOps[2] = 7'b0110111;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 10);
      case (sel)
        0, 1:    op = 7'b0110011;
        2, 3:    op = 7'b0010011;
        4, 5:    op = 7'b0000011;
        6, 7:    op = 7'b0100011;
        8, 9:    op = 7'b1100011;
        default: op = badOps[$urandom_range(0, 2)];
      endcase
      f3 = ($urandom_range(0, 9) == 0) ? 3'(2 + $urandom_range(0, 5)) : 3'($urandom_range(0, 1));
      z  = 1'($urandom);
      fw = ($urandom_range(0, 12) == 0) ? T : $urandom_range(0, T - 1);
      mw = ($urandom_range(0, 12) == 0) ? T : $urandom_range(0, T - 1);
      buildModel(op, f3, z, fw, mw);
      Op_i = op; Funct3_i = f3; Zero_i = z;
      foreach (q[k]) begin
        MemReady_i = q[k].rdy;
        start_i = 1'($urandom);
        #1 chk($sformatf("rand%0d_cyc%0d", n, k), outv(), q[k].o);
        @(posedge clk); #1;
      end
      if (q[q.size() - 1].o[0]) doReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
